// File: rtl/param_cpu_pkg.sv
// Shared encodings for param_cpu_core: opcodes, FSM state codes and the
// instruction field layout helper.
package param_cpu_pkg;

    localparam logic [2:0] OP_SUB   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_LOAD  = 3'b110;
    localparam logic [2:0] OP_STORE = 3'b111;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam int FLD_OP  = 0;
    localparam int FLD_RD  = 1;
    localparam int FLD_RS  = 2;
    localparam int FLD_IMM = 3;

    // LSB position of a field: op on top, then rd, then rs; imm starts at bit 0
    // and overlaps rs (imm's width equals the rd LSB position).
    function automatic int field_lsb(input int data_w, input int ridx_w, input int fld);
        case (fld)
            FLD_OP:  return data_w - 3;
            FLD_RD:  return data_w - 3 - ridx_w;
            FLD_RS:  return data_w - 3 - 2 * ridx_w;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/param_cpu_alu.sv
// Combinational ALU for the register-register opcodes (SUB/ADD/AND/OR/XOR);
// other opcodes yield zero and are never written back.
module param_cpu_alu
    import param_cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_SUB:  result = a - b;
            OP_ADD:  result = a + b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/param_cpu_core.sv
// Parametrised multicycle core with req/ack memory port, JZ and HALT.
// Build option: CPU_REG0_ZERO_EN makes r0 a hardwired zero register.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_FETCH | read request at PC; IR latched on ack
// ST_EXEC  | ALU write-back, JZ resolution, or hand-off to ST_MEM
// ST_MEM   | LOAD/STORE request at imm; completes on ack
// ST_HALT  | JZ to itself taken; left only through reset
module param_cpu_core
    import param_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] alu_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              halted
);

    localparam int RIDX_W = $clog2(NREGS);
    localparam int OP_LSB = field_lsb(DATA_W, RIDX_W, FLD_OP);
    localparam int RD_LSB = field_lsb(DATA_W, RIDX_W, FLD_RD);
    localparam int RS_LSB = field_lsb(DATA_W, RIDX_W, FLD_RS);
    localparam int IMM_W  = RD_LSB;
    localparam logic [ADDR_W-1:0] PC_ONE = 1;

`ifdef CPU_REG0_ZERO_EN
    localparam bit REG0_ZERO = 1'b1;
`else
    localparam bit REG0_ZERO = 1'b0;
`endif

    logic [2:0]        state;
    logic [DATA_W-1:0] ir;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] regs [NREGS];

    logic [2:0]        op;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs;
    logic [ADDR_W-1:0] imm;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] alu_res;
    logic [ADDR_W-1:0] pc_inc;
    logic              is_alu;
    logic              rd_wr_ok;

    assign op = ir[OP_LSB +: 3];
    assign rd = ir[RD_LSB +: RIDX_W];
    assign rs = ir[RS_LSB +: RIDX_W];

    if (IMM_W >= ADDR_W) begin : g_imm_trunc
        assign imm = ir[ADDR_W-1:0];
    end else begin : g_imm_zext
        assign imm = {{(ADDR_W-IMM_W){1'b0}}, ir[IMM_W-1:0]};
    end

    // With r0 hardwired, its storage is never written after reset, so plain
    // reads of regs[0] already return zero.
    assign rd_val   = regs[rd];
    assign rs_val   = regs[rs];
    assign rd_wr_ok = !(REG0_ZERO && (rd == '0));
    assign is_alu   = (op <= OP_XOR);
    assign pc_inc   = pc + PC_ONE;

    param_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op),
        .a      (rd_val),
        .b      (rs_val),
        .result (alu_res)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            ir      <= '0;
            pc      <= '0;
            alu_out <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_alu) begin
                        if (rd_wr_ok) begin
                            regs[rd] <= alu_res;
                        end
                        alu_out <= alu_res;
                        pc      <= pc_inc;
                        state   <= ST_FETCH;
                    end else if (op == OP_JZ) begin
                        if (rd_val == '0) begin
                            if (imm == pc) begin
                                state <= ST_HALT;
                            end else begin
                                pc    <= imm;
                                state <= ST_FETCH;
                            end
                        end else begin
                            pc    <= pc_inc;
                            state <= ST_FETCH;
                        end
                    end else begin
                        state <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        if (op == OP_LOAD && rd_wr_ok) begin
                            regs[rd] <= mem_rdata;
                        end
                        pc    <= pc_inc;
                        state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Request signals are pure decodes of state/PC/IR, so they stay stable
    // for as long as the memory withholds ack.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_addr = imm;
                if (op == OP_STORE) begin
                    mem_we    = 1'b1;
                    mem_wdata = rd_val;
                end
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign pc_out = pc;
    assign busy   = (state != ST_IDLE) && (state != ST_HALT);
    assign halted = (state == ST_HALT);

endmodule

// File: tb/tb_param_cpu_core.sv
// Directed bench for param_cpu_core: table of small programs run to HALT,
// plus hand sequences for reset behaviour and a reset during a stalled STORE.
module tb_param_cpu_core;

    logic       clock;
    logic       reset;
    logic       start;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_rdata;
    logic       mem_req;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] alu_out;
    logic [4:0] pc_out;
    logic       busy;
    logic       halted;

    logic [7:0] mem [32];

    int n_total = 0;
    int n_bad   = 0;

    // ack_mode 0: ack tied high; 1: random waits (>=1 low cycle per request);
    // 2: ack reads only, writes stall forever.
    int         ack_mode  = 0;
    int         n_writes  = 0;
    logic [4:0] last_waddr = '0;
    bit         in_req    = 1'b0;
    int         wait_left = 0;
    bit         stab_pend = 1'b0;
    logic [4:0] hold_addr;
    logic       hold_we;
    logic [7:0] hold_wdata;

`ifdef CPU_REG0_ZERO_EN
    localparam logic [7:0] R0_SUM = 8'h03;
`else
    localparam logic [7:0] R0_SUM = 8'h08;
`endif

    typedef struct packed {
        logic [63:0] prog;
        logic [1:0]  mode;
        logic [4:0]  exp_pc;
        logic [7:0]  exp_alu;
        logic [4:0]  chk_addr;
        logic [7:0]  chk_val;
        logic [3:0]  exp_writes;
        logic [7:0]  exp_cyc;
    } vec_t;

    param_cpu_core #(.DATA_W(8), .ADDR_W(5), .NREGS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .alu_out   (alu_out),
        .pc_out    (pc_out),
        .busy      (busy),
        .halted    (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_addr];

    // Memory model: decides ack for the coming edge and commits writes.
    always @(negedge clock) begin
        if (stab_pend) begin
            n_total++;
            if (!mem_req || mem_addr !== hold_addr || mem_we !== hold_we || mem_wdata !== hold_wdata) begin
                n_bad++;
                $display("FAIL hold_stable: got req=%0b addr=%0h we=%0b wdata=%0h expected req=1 addr=%0h we=%0b wdata=%0h",
                         mem_req, mem_addr, mem_we, mem_wdata, hold_addr, hold_we, hold_wdata);
            end
        end
        case (ack_mode)
            1: begin
                if (!mem_req) begin
                    mem_ack = ($urandom_range(0, 1) == 1);
                    in_req  = 1'b0;
                end else if (!in_req || mem_ack) begin
                    in_req    = 1'b1;
                    wait_left = $urandom_range(1, 3);
                    mem_ack   = 1'b0;
                end else begin
                    wait_left--;
                    mem_ack = (wait_left == 0);
                end
            end
            2:       mem_ack = mem_req && !mem_we;
            default: mem_ack = 1'b1;
        endcase
        stab_pend  = (ack_mode == 1) && mem_req && !mem_ack;
        hold_addr  = mem_addr;
        hold_we    = mem_we;
        hold_wdata = mem_wdata;
        if (mem_req && mem_we && mem_ack) begin
            mem[mem_addr] = mem_wdata;
            n_writes++;
            last_waddr = mem_addr;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [63:0] prog, input logic [1:0] mode,
                                input logic [4:0] pc, input logic [7:0] alu,
                                input logic [4:0] ca, input logic [7:0] cv,
                                input logic [3:0] nw, input logic [7:0] cyc);
        vec_t v;
        v.prog       = prog;
        v.mode       = mode;
        v.exp_pc     = pc;
        v.exp_alu    = alu;
        v.chk_addr   = ca;
        v.chk_val    = cv;
        v.exp_writes = nw;
        v.exp_cyc    = cyc;
        return v;
    endfunction

    task automatic load_mem(input logic [63:0] prog);
        for (int a = 0; a < 32; a++) mem[a] = 8'h00;
        for (int a = 0; a < 8; a++) mem[a] = prog[8*a +: 8];
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        bit done;
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock);
        load_mem(v.prog);
        ack_mode = int'(v.mode);
        @(negedge clock);
        n_writes = 0;
        reset    = 1'b0;
        start    = 1'b1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            @(negedge clock);
            cyc++;
            start = 1'b0;
            if (halted) done = 1'b1;
        end
        chk($sformatf("v%0d_halt", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_pc", idx), 32'(pc_out), 32'(v.exp_pc));
        chk($sformatf("v%0d_alu", idx), 32'(alu_out), 32'(v.exp_alu));
        chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d_req", idx), 32'(mem_req), 32'd0);
        chk($sformatf("v%0d_mem", idx), 32'(mem[v.chk_addr]), 32'(v.chk_val));
        chk($sformatf("v%0d_writes", idx), 32'(n_writes), 32'(v.exp_writes));
        if (v.exp_writes != 0)
            chk($sformatf("v%0d_waddr", idx), 32'(last_waddr), 32'(v.chk_addr));
        if (v.exp_cyc != 0)
            chk($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(v.exp_cyc));
    endtask

    initial begin
        vec_t vecs [9];
        bit   found;

        // prog bytes: address 0 in the low byte
        vecs[0] = mk(64'h03_05_00_A4_ED_2C_D7_CE, 2'd0, 5'd4, 8'h08, 5'd5, 8'h08, 4'd1, 8'd14);
        vecs[1] = mk(64'h03_05_00_A4_ED_2C_D7_CE, 2'd1, 5'd4, 8'h08, 5'd5, 8'h08, 4'd1, 8'd0);
        vecs[2] = mk(64'h01_00_A5_BC_2E_2E_20_DF, 2'd0, 5'd5, 8'h02, 5'd7, 8'h01, 4'd0, 8'd14);
        vecs[3] = mk(64'h01_00_00_00_A3_ED_0C_D7, 2'd0, 5'd3, 8'hFF, 5'd5, 8'hFF, 4'd1, 8'd11);
        vecs[4] = mk(64'h00_5A_00_AC_8A_ED_2A_CE, 2'd0, 5'd4, 8'h00, 5'd5, 8'hB4, 4'd1, 8'd13);
        vecs[5] = mk(64'h3C_5A_00_A4_8C_4C_D7_CE, 2'd0, 5'd4, 8'h24, 5'd5, 8'h00, 4'd0, 8'd13);
        vecs[6] = mk(64'h3C_5A_00_00_A3_6C_D7_CE, 2'd0, 5'd3, 8'h7E, 5'd6, 8'h5A, 4'd0, 8'd11);
        vecs[7] = mk(64'h01_00_00_00_00_D7_A1_B2, 2'd0, 5'd1, 8'h00, 5'd7, 8'h01, 4'd0, 8'd68);
        vecs[8] = mk(64'h03_05_00_B4_ED_28_C6_CF, 2'd1, 5'd4, R0_SUM, 5'd5, R0_SUM, 4'd1, 8'd0);

        reset = 1'b1;
        start = 1'b0;
        load_mem(64'h0);
        repeat (2) @(negedge clock);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_alu", 32'(alu_out), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_nostart_busy", 32'(busy), 32'd0);
        chk("idle_nostart_req", 32'(mem_req), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset while a STORE is stalled waiting for ack.
        reset = 1'b1;
        start = 1'b0;
        @(negedge clock);
        load_mem(64'h00_5A_77_00_00_00_ED_CE);
        ack_mode = 2;
        @(negedge clock);
        n_writes = 0;
        reset    = 1'b0;
        start    = 1'b1;
        found    = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (mem_req && mem_we) found = 1'b1;
        end
        chk("mst_reached", 32'(found), 32'd1);
        chk("mst_addr", 32'(mem_addr), 32'd5);
        chk("mst_wdata", 32'(mem_wdata), 32'h5A);
        chk("mst_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clock);
        chk("mst_stall_req", 32'(mem_req), 32'd1);
        chk("mst_stall_addr", 32'(mem_addr), 32'd5);
        reset = 1'b1;
        @(negedge clock);
        chk("mst_rst_req", 32'(mem_req), 32'd0);
        chk("mst_rst_we", 32'(mem_we), 32'd0);
        chk("mst_rst_addr", 32'(mem_addr), 32'd0);
        chk("mst_rst_wdata", 32'(mem_wdata), 32'd0);
        chk("mst_rst_pc", 32'(pc_out), 32'd0);
        chk("mst_rst_alu", 32'(alu_out), 32'd0);
        chk("mst_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("mst_after_busy", 32'(busy), 32'd0);
        chk("mst_after_req", 32'(mem_req), 32'd0);
        chk("mst_mem5", 32'(mem[5]), 32'h77);
        chk("mst_writes", 32'(n_writes), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
